// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 keypad matrix scanner with row synchronizer, frame
// debouncer and a single-event valid/ack key output with overrun flag.
module keypad_scan #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_held,
    output logic       overrun
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [3:0] MATCH_MAX = 4'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        PRESSED  = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [1:0]    acc_n_q, acc_n_d;
    logic [3:0]    acc_code_q, acc_code_d;
    logic          frm_done_q, frm_done_d;
    logic [1:0]    frm_n_q, frm_n_d;
    logic [3:0]    frm_code_q, frm_code_d;
    logic [4:0]    prev_cand_q, prev_cand_d;
    logic          prev_ok_q, prev_ok_d;
    logic [3:0]    match_q, match_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          overrun_q, overrun_d;

    logic          sample;
    logic [3:0]    pressed;
    logic [2:0]    col_sum;
    logic [1:0]    col_n;
    logic [1:0]    row_idx;
    logic [1:0]    base_n;
    logic [2:0]    sum_n;
    logic [1:0]    merged_n;
    logic [3:0]    merged_code;
    logic          f_empty;
    logic          f_single;
    logic          f_ghost;
    logic [4:0]    cand;
    logic          same;
    logic [3:0]    match_inc;
    logic          hit;
    logic          accept;

    // Per-column key count (saturated at 2) and row of the pressed key
    always_comb begin
        pressed = ~sync2_q;
        col_sum = 3'(pressed[0]) + 3'(pressed[1])
                + 3'(pressed[2]) + 3'(pressed[3]);
        col_n   = (col_sum > 3'd1) ? 2'd2 : col_sum[1:0];
        row_idx = 2'd0;
        case (1'b1)
            pressed[0]: row_idx = 2'd0;
            pressed[1]: row_idx = 2'd1;
            pressed[2]: row_idx = 2'd2;
            pressed[3]: row_idx = 2'd3;
            default:    row_idx = 2'd0;
        endcase
        base_n      = (col_idx_q == 2'd0) ? 2'd0 : acc_n_q;
        sum_n       = 3'(base_n) + 3'(col_n);
        merged_n    = (sum_n > 3'd1) ? 2'd2 : sum_n[1:0];
        merged_code = (col_n == 2'd1) ? {row_idx, col_idx_q}
                                      : acc_code_q;
    end

    always_comb begin
        sample     = (slot_q == SLOT_LAST);
        sync1_d    = row;
        sync2_d    = sync1_q;
        slot_d     = sample ? '0 : slot_q + SW'(1);
        col_idx_d  = sample ? col_idx_q + 2'd1 : col_idx_q;
        acc_n_d    = acc_n_q;
        acc_code_d = acc_code_q;
        frm_done_d = 1'b0;
        frm_n_d    = frm_n_q;
        frm_code_d = frm_code_q;
        if (sample) begin
            acc_n_d    = merged_n;
            acc_code_d = merged_code;
            if (col_idx_q == 2'd3) begin
                frm_done_d = 1'b1;
                frm_n_d    = merged_n;
                frm_code_d = merged_code;
            end
        end
    end

    // Frame-to-frame match counter; a ghost frame breaks any match chain
    always_comb begin
        f_empty     = (frm_n_q == 2'd0);
        f_single    = (frm_n_q == 2'd1);
        f_ghost     = frm_n_q[1];
        cand        = {f_empty, f_empty ? 4'd0 : frm_code_q};
        same        = prev_ok_q && (cand == prev_cand_q);
        match_inc   = (match_q == MATCH_MAX) ? match_q
                                             : match_q + 4'd1;
        match_d     = match_q;
        prev_cand_d = prev_cand_q;
        prev_ok_d   = prev_ok_q;
        if (frm_done_q) begin
            match_d     = (f_ghost || !same) ? 4'd0 : match_inc;
            prev_cand_d = cand;
            prev_ok_d   = !f_ghost;
        end
        hit = (match_d == MATCH_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        if (frm_done_q) begin
            unique case (state_q)
                IDLE: begin
                    if (f_single) begin
                        state_d = PRESS_DB;
                        cand_d  = frm_code_q;
                    end
                end
                PRESS_DB: begin
                    if (f_empty) begin
                        state_d = IDLE;
                    end else if (f_single) begin
                        if (frm_code_q != cand_q) begin
                            cand_d = frm_code_q;
                        end else if (hit) begin
                            state_d = PRESSED;
                        end
                    end
                end
                PRESSED: begin
                    if (f_empty) begin
                        state_d = REL_DB;
                    end
                end
                REL_DB: begin
                    if (!f_empty) begin
                        state_d = PRESSED;
                    end else if (hit) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        accept = frm_done_q && (state_q == PRESS_DB) && f_single
              && (frm_code_q == cand_q) && hit;
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overrun_d   = overrun_q;
        if (key_ack && key_valid_q) begin
            key_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (accept) begin
            if (!key_valid_q || key_ack) begin
                key_code_d  = frm_code_q;
                key_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q     <= 4'b1111;
            sync2_q     <= 4'b1111;
            slot_q      <= '0;
            col_idx_q   <= 2'd0;
            acc_n_q     <= 2'd0;
            acc_code_q  <= 4'd0;
            frm_done_q  <= 1'b0;
            frm_n_q     <= 2'd0;
            frm_code_q  <= 4'd0;
            prev_cand_q <= 5'b10000;
            prev_ok_q   <= 1'b1;
            match_q     <= 4'd0;
            cand_q      <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            slot_q      <= slot_d;
            col_idx_q   <= col_idx_d;
            acc_n_q     <= acc_n_d;
            acc_code_q  <= acc_code_d;
            frm_done_q  <= frm_done_d;
            frm_n_q     <= frm_n_d;
            frm_code_q  <= frm_code_d;
            prev_cand_q <= prev_cand_d;
            prev_ok_q   <= prev_ok_d;
            match_q     <= match_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign col       = ~(4'b0001 << col_idx_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign overrun   = overrun_q;
    assign key_held  = (state_q == PRESSED) || (state_q == REL_DB);

endmodule
